mp_reg_bank: RTL and testbench

//  Bank of NREGS masked-write registers with NPORTS independent write ports, single clock.

---
 rtl/mp_reg_bank.sv | 140 ++++++++++++++
 tb/tb_mp_reg_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_reg_bank.sv
// Multi-port masked-write register bank with change tracking.
// Every register whose value changes is reported once, round-robin, on a valid/ready update stream.
module mp_reg_bank #(
    parameter int               WIDTH       = 8,
    parameter int               NREGS       = 4,
    parameter int               NPORTS      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] RESET_MASK  = '1
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              clr,
    input  logic [NPORTS*$clog2(NREGS)-1:0]   wr_addr,
    input  logic [NPORTS*WIDTH-1:0]           wr_mask,
    input  logic [NPORTS*WIDTH-1:0]           wr_data,
    output logic [NREGS*WIDTH-1:0]            value_out,
    output logic                              upd_valid,
    input  logic                              upd_ready,
    output logic [$clog2(NREGS)-1:0]          upd_addr,
    output logic [WIDTH-1:0]                  upd_data
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, HOLD} state_e;

    logic [WIDTH-1:0] val_q  [NREGS];
    logic [WIDTH-1:0] val_d  [NREGS];
    logic [WIDTH-1:0] merged [NREGS];
    logic [NREGS-1:0] dirty_q, dirty_d, changed;
    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    upd_addr_q, upd_addr_d;
    logic [WIDTH-1:0] upd_data_q, upd_data_d;
    logic             found;
    logic [AW-1:0]    pick;

    // Ports are folded in ascending order so the highest port wins on overlapping bits.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            merged[r] = val_q[r];
            for (int p = 0; p < NPORTS; p++) begin
                if ((wr_mask[p*WIDTH +: WIDTH] != '0) && (int'(wr_addr[p*AW +: AW]) == r)) begin
                    merged[r] = (wr_data[p*WIDTH +: WIDTH] & wr_mask[p*WIDTH +: WIDTH]) |
                                (merged[r] & ~wr_mask[p*WIDTH +: WIDTH]);
                end
            end
            changed[r] = (merged[r] != val_q[r]);
        end
    end

    // First dirty register at or after the round-robin pointer, wrapping at NREGS.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREGS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREGS) begin
                idx = idx - NREGS;
            end
            if (!found && dirty_q[idx]) begin
                found = 1'b1;
                pick  = AW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        upd_addr_d = upd_addr_q;
        upd_data_d = upd_data_q;
        dirty_d    = dirty_q;
        for (int r = 0; r < NREGS; r++) begin
            val_d[r] = merged[r];
        end

        if ((state_q == IDLE) || upd_ready) begin
            if (found) begin
                state_d          = HOLD;
                upd_addr_d       = pick;
                upd_data_d       = val_q[pick];
                dirty_d[pick]    = 1'b0;
                ptr_d            = (pick == AW'(NREGS - 1)) ? '0 : pick + AW'(1);
            end else begin
                state_d = IDLE;
            end
        end

        // A change landing on the capture cycle re-arms the flag so the new value is reported later.
        dirty_d = dirty_d | changed;

        if (clr) begin
            for (int r = 0; r < NREGS; r++) begin
                val_d[r] = (RESET_VALUE & RESET_MASK) | (val_q[r] & ~RESET_MASK);
            end
            dirty_d    = '0;
            state_d    = IDLE;
            ptr_d      = '0;
            upd_addr_d = upd_addr_q;
            upd_data_d = upd_data_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < NREGS; r++) begin
                val_q[r] <= RESET_VALUE & RESET_MASK;
            end
            dirty_q    <= '0;
            state_q    <= IDLE;
            ptr_q      <= '0;
            upd_addr_q <= '0;
            upd_data_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                val_q[r] <= val_d[r];
            end
            dirty_q    <= dirty_d;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            upd_addr_q <= upd_addr_d;
            upd_data_q <= upd_data_d;
        end
    end

    always_comb begin
        value_out = '0;
        for (int r = 0; r < NREGS; r++) begin
            value_out[r*WIDTH +: WIDTH] = val_q[r];
        end
    end

    assign upd_valid = (state_q == HOLD);
    assign upd_addr  = upd_addr_q;
    assign upd_data  = upd_data_q;

endmodule

// File: tb/tb_mp_reg_bank.sv
// Bench for mp_reg_bank: a 4-register/3-port bank with a partial reset mask carries the main
// scenarios; a 3-register bank covers out-of-range addresses.
module tb_mp_reg_bank;

    logic        clk;
    int          compared;
    int          mismatched;
    logic [9:0]  sbQ[$];

    logic        rstnA, clrA, validA, readyA;
    logic [5:0]  addrA;
    logic [23:0] maskA, dataA;
    logic [31:0] valueA;
    logic [1:0]  updAddrA;
    logic [7:0]  updDataA;

    logic        rstnB, clrB, validB, readyB;
    logic [1:0]  addrB;
    logic [7:0]  maskB, dataB;
    logic [23:0] valueB;
    logic [1:0]  updAddrB;
    logic [7:0]  updDataB;

    mp_reg_bank #(
        .WIDTH(8), .NREGS(4), .NPORTS(3), .RESET_VALUE(8'h5A), .RESET_MASK(8'hF0)
    ) dutA (
        .clk(clk), .nrst(rstnA), .clr(clrA),
        .wr_addr(addrA), .wr_mask(maskA), .wr_data(dataA),
        .value_out(valueA),
        .upd_valid(validA), .upd_ready(readyA), .upd_addr(updAddrA), .upd_data(updDataA)
    );

    mp_reg_bank #(
        .WIDTH(8), .NREGS(3), .NPORTS(1)
    ) dutB (
        .clk(clk), .nrst(rstnB), .clr(clrB),
        .wr_addr(addrB), .wr_mask(maskB), .wr_data(dataB),
        .value_out(valueB),
        .upd_valid(validB), .upd_ready(readyB), .upd_addr(updAddrB), .upd_data(updDataB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [1:0] addr, input logic [7:0] mask,
                                 input logic [7:0] data);
        addrA[port*2 +: 2] = addr;
        maskA[port*8 +: 8] = mask;
        dataA[port*8 +: 8] = data;
    endtask

    task automatic clearStimulus();
        addrA = '0;
        maskA = '0;
        dataA = '0;
    endtask

    task automatic pushExpected(input logic [1:0] addr, input logic [7:0] data);
        sbQ.push_back({addr, data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] regA(input int r);
        return valueA[r*8 +: 8];
    endfunction

    // Records are taken from the scoreboard in the half cycle before the accepting edge.
    always @(negedge clk) begin
        if (rstnA && !clrA && validA && readyA) begin
            if (sbQ.size() == 0) begin
                checkOutput("spurious record", 32'(validA), 32'd0);
            end else begin
                checkOutput("record addr/data", 32'({updAddrA, updDataA}), 32'(sbQ.pop_front()));
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rstnA  = 1'b0;
        clrA   = 1'b0;
        readyA = 1'b0;
        clearStimulus();
        rstnB  = 1'b0;
        clrB   = 1'b0;
        readyB = 1'b1;
        addrB  = '0;
        maskB  = '0;
        dataB  = '0;

        tick();
        tick();
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("reset value reg%0d", r), 32'(regA(r)), 32'h50);
        end
        checkOutput("reset upd_valid", 32'(validA), 32'd0);
        checkOutput("reset upd_addr", 32'(updAddrA), 32'd0);
        checkOutput("reset upd_data", 32'(updDataA), 32'd0);
        checkOutput("reset bank B", 32'(valueB), 32'd0);
        rstnA = 1'b1;
        rstnB = 1'b1;
        tick();

        // Port priority on overlapping bits.
        readyA = 1'b1;
        applyStimulus(0, 2'd1, 8'hFF, 8'h11);
        applyStimulus(1, 2'd1, 8'h0F, 8'h2E);
        pushExpected(2'd1, 8'h1E);
        tick();
        clearStimulus();
        checkOutput("merge reg1", 32'(regA(1)), 32'h1E);
        checkOutput("valid n+1", 32'(validA), 32'd0);
        tick();
        checkOutput("valid n+2", 32'(validA), 32'd1);
        checkOutput("upd_addr n+2", 32'(updAddrA), 32'd1);
        checkOutput("upd_data n+2", 32'(updDataA), 32'h1E);
        tick();
        checkOutput("idle after record", 32'(validA), 32'd0);

        // Rewriting identical bits must not produce a record.
        applyStimulus(0, 2'd1, 8'hFF, 8'h1E);
        tick();
        clearStimulus();
        checkOutput("same-value reg1", 32'(regA(1)), 32'h1E);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no-change valid", 32'(validA), 32'd0);
        end

        clrA = 1'b1;
        tick();
        clrA = 1'b0;
        checkOutput("clr reg1", 32'(regA(1)), 32'h5E);
        checkOutput("clr reg0", 32'(regA(0)), 32'h50);

        // Round robin under backpressure.
        readyA = 1'b0;
        applyStimulus(0, 2'd3, 8'hFF, 8'h33);
        applyStimulus(1, 2'd0, 8'hFF, 8'h30);
        applyStimulus(2, 2'd2, 8'hFF, 8'h22);
        pushExpected(2'd0, 8'h30);
        pushExpected(2'd2, 8'h22);
        pushExpected(2'd3, 8'h33);
        tick();
        clearStimulus();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("rr held valid", 32'(validA), 32'd1);
            checkOutput("rr held addr", 32'(updAddrA), 32'd0);
            checkOutput("rr held data", 32'(updDataA), 32'h30);
            tick();
        end
        readyA = 1'b1;
        checkOutput("rr first addr", 32'(updAddrA), 32'd0);
        tick();
        checkOutput("rr second valid", 32'(validA), 32'd1);
        checkOutput("rr second addr", 32'(updAddrA), 32'd2);
        tick();
        checkOutput("rr third valid", 32'(validA), 32'd1);
        checkOutput("rr third addr", 32'(updAddrA), 32'd3);
        tick();
        checkOutput("rr drained", 32'(validA), 32'd0);

        // Coalescing while dirty, and a change on the capture cycle.
        readyA = 1'b0;
        applyStimulus(0, 2'd2, 8'hFF, 8'h01);
        pushExpected(2'd2, 8'h01);
        tick();
        applyStimulus(0, 2'd2, 8'hFF, 8'h02);
        tick();
        checkOutput("race capture addr", 32'(updAddrA), 32'd2);
        checkOutput("race capture data", 32'(updDataA), 32'h01);
        checkOutput("race reg2 after 02", 32'(regA(2)), 32'h02);
        applyStimulus(0, 2'd2, 8'hFF, 8'h03);
        pushExpected(2'd2, 8'h03);
        tick();
        clearStimulus();
        checkOutput("coalesce reg2", 32'(regA(2)), 32'h03);
        tick();
        tick();
        checkOutput("coalesce held valid", 32'(validA), 32'd1);
        checkOutput("coalesce held data", 32'(updDataA), 32'h01);
        applyStimulus(0, 2'd2, 8'hFF, 8'h04);
        readyA = 1'b1;
        pushExpected(2'd2, 8'h04);
        tick();
        clearStimulus();
        checkOutput("capture-cycle data", 32'(updDataA), 32'h03);
        checkOutput("capture-cycle reg2", 32'(regA(2)), 32'h04);
        tick();
        checkOutput("late record valid", 32'(validA), 32'd1);
        checkOutput("late record data", 32'(updDataA), 32'h04);
        tick();
        checkOutput("coalesce drained", 32'(validA), 32'd0);

        // clr mid-HOLD with another register still dirty; clr also overrides a write.
        readyA = 1'b0;
        applyStimulus(0, 2'd0, 8'hFF, 8'hA5);
        applyStimulus(1, 2'd3, 8'hFF, 8'h3C);
        tick();
        clearStimulus();
        tick();
        checkOutput("pre-clr valid", 32'(validA), 32'd1);
        clrA = 1'b1;
        applyStimulus(2, 2'd1, 8'hFF, 8'hFF);
        tick();
        clrA = 1'b0;
        clearStimulus();
        checkOutput("clr drops valid", 32'(validA), 32'd0);
        checkOutput("clr reg0", 32'(regA(0)), 32'h55);
        checkOutput("clr overrides write", 32'(regA(1)), 32'h5E);
        checkOutput("clr reg2", 32'(regA(2)), 32'h54);
        checkOutput("clr reg3", 32'(regA(3)), 32'h5C);
        readyA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post-clr valid", 32'(validA), 32'd0);
        end

        // Reset while a record is pending.
        readyA = 1'b0;
        applyStimulus(0, 2'd1, 8'hFF, 8'h99);
        tick();
        clearStimulus();
        tick();
        checkOutput("pre-reset valid", 32'(validA), 32'd1);
        checkOutput("pre-reset data", 32'(updDataA), 32'h99);
        rstnA = 1'b0;
        #1;
        checkOutput("async reset valid", 32'(validA), 32'd0);
        checkOutput("async reset reg1", 32'(regA(1)), 32'h50);
        tick();
        rstnA = 1'b1;
        tick();
        checkOutput("post-reset valid", 32'(validA), 32'd0);

        // Out-of-range address on the 3-register bank, then an in-range control write.
        addrB = 2'd3;
        maskB = 8'hFF;
        dataB = 8'h77;
        tick();
        maskB = '0;
        tick();
        tick();
        checkOutput("oob values", 32'(valueB), 32'd0);
        checkOutput("oob valid", 32'(validB), 32'd0);
        addrB = 2'd2;
        maskB = 8'hFF;
        tick();
        maskB = '0;
        checkOutput("B reg2", 32'(valueB[23:16]), 32'h77);
        tick();
        checkOutput("B record valid", 32'(validB), 32'd1);
        checkOutput("B record addr", 32'(updAddrB), 32'd2);
        checkOutput("B record data", 32'(updDataB), 32'h77);

        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
